avr_spi_master: RTL

Synthesizable SPI master that drives the FPGA's AVR-side SPI slave pins (spics_n/spick/spido, samples spidi). It reproduces the AVR protocol: chip-select low, one register-address byte, data byte(s), chip-select high. The block sits in the bench or in a debug build in place of the ATmega. It lets Z80-side or bench logic read and write slave registers (config, kbd, gluclock, etc.) with a simple request/acknowledge handshake.

---
 rtl/avr_spi_master_if.sv | 23 ++
 rtl/avr_spi_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/avr_spi_master_if.sv
// rtl/avr_spi_master_if.sv - host-side request/acknowledge bundle for avr_spi_master
interface avr_spi_master_if;
    logic       req;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       more;
    logic       busy;
    logic [7:0] rdata;
    logic       rvalid;
    logic       ack;

    // master: the logic issuing register accesses
    modport master (
        output req, addr, wdata, more,
        input  busy, rdata, rvalid, ack
    );

    // slave: the SPI engine serving those accesses
    modport slave (
        input  req, addr, wdata, more,
        output busy, rdata, rvalid, ack
    );
endinterface

// File: rtl/avr_spi_master.sv
// rtl/avr_spi_master.sv - AVR-protocol SPI master (mode 0, MSB first); optional burst via AVR_SPI_BURST_EN
module avr_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8
) (
    input  logic            fclk,
    input  logic            rst_n,
    avr_spi_master_if.slave host,
    output logic            spics_n,
    output logic            spick,
    output logic            spido,
    input  logic            spidi
);

    // Counters hold "cycles remaining minus one" so a phase of N cycles
    // ends on the edge where the counter is already zero.
    localparam logic [7:0] DIV_LD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
    localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_A,
        SHIFT_D,
        HOLD,
        GAP
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [7:0] div_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [7:0] wdata_q;
    logic       busy_q;
    logic [7:0] rdata_q;
    logic       rvalid_q;
    logic       ack_q;

`ifndef AVR_SPI_BURST_EN
    // Without burst support the continue flag has no effect.
    logic unused_more;
    assign unused_more = host.more;
`endif

    assign host.busy   = busy_q;
    assign host.rdata  = rdata_q;
    assign host.rvalid = rvalid_q;
    assign host.ack    = ack_q;

    // Transaction sequencer: chip-select framing, bit timing and shifting.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            div_cnt  <= 8'd0;
            bit_cnt  <= 3'd0;
            tx_sr    <= 8'd0;
            rx_sr    <= 8'd0;
            wdata_q  <= 8'd0;
            busy_q   <= 1'b0;
            rdata_q  <= 8'h00;
            rvalid_q <= 1'b0;
            ack_q    <= 1'b0;
            spics_n  <= 1'b1;
            spick    <= 1'b0;
            spido    <= 1'b1;
        end else begin
            rvalid_q <= 1'b0;
            ack_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.req) begin
                        tx_sr   <= host.addr;
                        wdata_q <= host.wdata;
                        busy_q  <= 1'b1;
                        spics_n <= 1'b0;
                        spido   <= host.addr[7];
                        cnt     <= SETUP_LD;
                        state   <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == 8'd0) begin
                        div_cnt <= DIV_LD;
                        bit_cnt <= 3'd0;
                        state   <= SHIFT_A;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                SHIFT_A, SHIFT_D: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else begin
                        div_cnt <= DIV_LD;
                        if (!spick) begin
                            // Rising edge mid-bit: slave data is sampled here.
                            spick <= 1'b1;
                            rx_sr <= {rx_sr[6:0], spidi};
                        end else begin
                            // Falling edge ends the bit and presents the next one.
                            spick   <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt != 3'd7) begin
                                tx_sr <= {tx_sr[6:0], 1'b0};
                                spido <= tx_sr[6];
                            end else if (state == SHIFT_A) begin
                                tx_sr <= wdata_q;
                                spido <= wdata_q[7];
                                state <= SHIFT_D;
                            end else begin
                                rdata_q  <= rx_sr;
                                rvalid_q <= 1'b1;
`ifdef AVR_SPI_BURST_EN
                                if (host.more) begin
                                    wdata_q <= host.wdata;
                                    tx_sr   <= host.wdata;
                                    spido   <= host.wdata[7];
                                end else begin
                                    cnt   <= HOLD_LD;
                                    state <= HOLD;
                                end
`else
                                cnt   <= HOLD_LD;
                                state <= HOLD;
`endif
                            end
                        end
                    end
                end

                HOLD: begin
                    if (cnt == 8'd0) begin
                        spics_n <= 1'b1;
                        cnt     <= GAP_LD;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                GAP: begin
                    if (cnt == 8'd0) begin
                        ack_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
